alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the team's combinational N-bit ALU.
- Adds an 8-operation opcode set, registered results with status flags, and a multi-cycle shift-add multiplier.
- Uses valid/ready handshakes on both input and output, so it can sit between pipeline stages of a datapath that applies backpressure.

Parameters:
- N, 8, operand and result width (>= 4).
- SHW, $clog2(N), number of low B bits used as the shift amount (derived; not to be overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- A  input  N  operand A, unsigned/two's complement.
- B  input  N  operand B.
- op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts result.
- ALU_out  output  N  result.
- carry  output  1  carry/borrow/shifted-out bit/product overflow.
- ovf  output  1  signed overflow (ADD/SUB only).
- zero  output  1  ALU_out == 0.

Behaviour:
- Reset (rst_n low, any time, including mid-multiply):
  - FSM goes to IDLE; any in-flight operation is discarded.
  - ALU_out=0, carry=0, ovf=0, zero=0, out_valid=0, in_ready=1 while IDLE after reset.
- FSM states: IDLE, MUL, HOLD.
- Acceptance: an operation is accepted when in_valid && in_ready. A, B and op are captured at that edge; later changes to the inputs are ignored.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This allows back-to-back single-cycle ops at full throughput.
- Ops 0-6 from IDLE or HOLD: compute and register on the accept edge. Go to HOLD with out_valid=1 on the next cycle (latency 1).
- Op 7 (MUL): go to MUL.
  - Shift-add over exactly N cycles, one multiplier bit per cycle, into a 2N-bit accumulator.
  - On the N-th cycle, load outputs and go to HOLD. out_valid rises N+1 cycles after the accept edge.
  - in_ready=0 throughout MUL.
- HOLD:
  - out_valid=1; outputs are held stable while out_ready=0.
  - On out_ready=1 with no new accept: go to IDLE, out_valid=0 next cycle, data outputs keep their last value.
  - On out_ready=1 with a simultaneous accept: start the new op. No bubble for ops 0-6.
- Arithmetic rules:
  - ADD: ALU_out=(A+B) mod 2^N; carry=bit N of the N+1-bit sum; ovf=(A[N-1]==B[N-1]) && (ALU_out[N-1]!=A[N-1]).
  - SUB: ALU_out=(A-B) mod 2^N; carry=1 iff A<B unsigned (borrow); ovf=(A[N-1]!=B[N-1]) && (ALU_out[N-1]!=A[N-1]).
  - AND/OR/XOR: bitwise; carry=0, ovf=0.
  - SHL/SHR: amount = B[SHW-1:0]; bits above are ignored. carry = last bit shifted out, or 0 when amount=0. ovf=0.
  - MUL: unsigned; ALU_out = low N bits of the product; carry = OR of the high N bits; ovf=0.
  - zero is computed from the final ALU_out for every op.

Test Plan:
- Reset, then ADD with N=8: A=5, B=23 -> ALU_out=28, carry=0, ovf=0, zero=0, out_valid exactly 1 cycle after accept. ADD A=100, B=200 -> ALU_out=44, carry=1, ovf=0. ADD A=100, B=100 -> ALU_out=200, carry=0, ovf=1. ADD A=255, B=255 -> ALU_out=254, carry=1, ovf=0.
- SUB A=10, B=12 -> ALU_out=254, carry=1, ovf=0. SUB A=12, B=12 -> ALU_out=0, zero=1, carry=0. SUB A=128, B=1 -> ALU_out=127, ovf=1.
- SHL A=0x81, B=0x09 (amount 1) -> ALU_out=0x02, carry=1. SHR A=0x81, B=0 -> ALU_out=0x81, carry=0. XOR A=0xAA, B=0xAA -> ALU_out=0, zero=1.
- MUL A=15, B=17 -> ALU_out=255, carry=0, out_valid 9 cycles after accept, in_ready=0 in between. MUL A=16, B=16 -> ALU_out=0, carry=1, zero=1.
- Backpressure: out_ready=0 for 5 cycles after an ADD result -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0,0x3C) -> next cycle ALU_out=0x30 with no bubble. Streaming 4 ADDs with out_ready=1 -> one result per cycle.
- Reset asserted on cycle 4 of a MUL -> out_valid=0 and all outputs 0 immediately (asynchronous). After release, ADD 1+1 -> ALU_out=2 with no residue from the aborted multiply.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq - clocked N-bit ALU with registered result/flags, a multi-cycle
// shift-add multiplier and valid/ready handshakes on input and output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/B/op are valid this cycle
//   in_ready   block can accept an operation this cycle
//   A, B       N-bit operands
//   op         0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
//   out_valid  ALU_out and flags are valid
//   out_ready  downstream accepts the result
//   ALU_out    N-bit result
//   carry      carry / borrow / last shifted-out bit / product overflow
//   ovf        signed overflow (ADD/SUB only)
//   zero       ALU_out == 0
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] ALU_out,
    output logic         carry,
    output logic         ovf,
    output logic         zero
);

    localparam int SHW = $clog2(N);
    localparam logic [SHW-1:0] LAST_COUNT = SHW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;

    logic [N:0]       sum;
    logic [N:0]       diff;
    logic [N:0]       shl_tmp;
    logic [N:0]       shr_tmp;
    logic [SHW-1:0]   shamt;

    logic [N-1:0]     alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    logic [2*N-1:0]   mul_acc;
    logic [2*N-1:0]   mul_mcand;
    logic [N-1:0]     mul_mplier;
    logic [SHW-1:0]   mul_count;
    logic [2*N-1:0]   mul_sum;
    logic             mul_last;

    assign accept = in_valid && in_ready;

    // Extra top bit on sum/diff gives carry-out and borrow directly. The
    // shifts use one guard bit so the last bit shifted out lands in it; with
    // a zero shift amount the guard bit stays 0.
    assign shamt   = B[SHW-1:0];
    assign sum     = {1'b0, A} + {1'b0, B};
    assign diff    = {1'b0, A} - {1'b0, B};
    assign shl_tmp = {1'b0, A} << shamt;
    assign shr_tmp = {A, 1'b0} >> shamt;

    assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_last = (mul_count == LAST_COUNT);

    // Single-cycle operation result, computed straight from the input ports
    // so it can be registered on the accept edge.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
                alu_ovf   = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
            end
            OP_SUB: begin
                alu_res   = diff[N-1:0];
                alu_carry = diff[N];
                alu_ovf   = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_SHL: begin
                alu_res   = shl_tmp[N-1:0];
                alu_carry = shl_tmp[N];
            end
            OP_SHR: begin
                alu_res   = shr_tmp[N:1];
                alu_carry = shr_tmp[0];
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. HOLD behaves like IDLE when a new op is accepted in
    // the same cycle the current result is taken, which removes the bubble.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    next_state = (op == OP_MUL) ? MUL : HOLD;
                end else if (state == HOLD && out_ready) begin
                    next_state = IDLE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    next_state = HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    end

    // Datapath: result/flag registers and the shift-add multiplier. The
    // multiplier consumes one multiplier bit per cycle for N cycles; the final
    // partial sum is loaded into the outputs on the same edge as the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_out    <= '0;
            carry      <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_count  <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                mul_acc    <= '0;
                mul_mcand  <= {{N{1'b0}}, A};
                mul_mplier <= B;
                mul_count  <= '0;
            end else begin
                ALU_out <= alu_res;
                carry   <= alu_carry;
                ovf     <= alu_ovf;
                zero    <= (alu_res == '0);
            end
        end else if (state == MUL) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_count  <= mul_count + SHW'(1);
            if (mul_last) begin
                ALU_out <= mul_sum[N-1:0];
                carry   <= |mul_sum[2*N-1:N];
                ovf     <= 1'b0;
                zero    <= (mul_sum[N-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq - directed testbench for alu_seq (N=8). Stimulus pushes the
// hand-computed expected result into a scoreboard queue on issue; a monitor
// pops and compares whenever a result is handed over (out_valid && out_ready).
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int N = 8;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SHL = 3'd5;
    localparam logic [2:0] SHR = 3'd6;
    localparam logic [2:0] MUL = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] ALU_out;
    logic         carry;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    typedef struct packed {
        logic [N-1:0] res;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Single comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one operation, waits (bounded) for acceptance and pushes the
    // expected response. Returns one time unit after the accept edge with
    // in_valid still high so consecutive calls stream back-to-back.
    task automatic applyStimulus(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] er, input logic ec, input logic eo,
                                 input logic ez, input bit push);
        int   w;
        exp_t e;
        op = o;
        A = a;
        B = b;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", int'(in_ready), 1);
        end else if (push) begin
            e.res = er;
            e.c = ec;
            e.o = eo;
            e.z = ez;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Called right after an accept: measures cycles until out_valid rises
    // (1 means visible in the cycle following the accept edge).
    task automatic waitValid(input string name, input int exp_lat, input bit check_busy);
        int lat;
        int busy_ok;
        lat = 1;
        busy_ok = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 0;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, lat, exp_lat);
        if (check_busy) checkOutput({name, "_in_ready_low"}, busy_ok, 1);
    endtask

    // Monitor: checks every handed-over result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", int'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_ALU_out", int'(ALU_out), int'(e.res));
                    checkOutput("sb_carry", int'(carry), int'(e.c));
                    checkOutput("sb_ovf", int'(ovf), int'(e.o));
                    checkOutput("sb_zero", int'(zero), int'(e.z));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cycle;

        // Reset state
        #12;
        checkOutput("reset_ALU_out", int'(ALU_out), 0);
        checkOutput("reset_carry", int'(carry), 0);
        checkOutput("reset_ovf", int'(ovf), 0);
        checkOutput("reset_zero", int'(zero), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with latency check
        applyStimulus(ADD, 8'd5, 8'd23, 8'd28, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        waitValid("add", 1, 1'b0);
        @(posedge clk);
        #1;

        // Streaming four ADDs: one accept per cycle
        start_cycle = cycle;
        applyStimulus(ADD, 8'd100, 8'd200, 8'd44, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(ADD, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(ADD, 8'd255, 8'd255, 8'd254, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(ADD, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stream_cycles", cycle - start_cycle, 4);

        // SUB, shifts and logic ops
        applyStimulus(SUB, 8'd10, 8'd12, 8'd254, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(SUB, 8'd12, 8'd12, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(SUB, 8'd128, 8'd1, 8'd127, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(SHL, 8'h81, 8'h09, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(SHR, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(SHR, 8'h06, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Multiplies
        applyStimulus(MUL, 8'd15, 8'd17, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        waitValid("mul15x17", 9, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(MUL, 8'd16, 8'd16, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        waitValid("mul16x16", 9, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure: result held for 5 cycles, then replaced with no bubble
        out_ready = 1'b0;
        applyStimulus(ADD, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", int'(out_valid), 1);
            checkOutput("bp_ALU_out", int'(ALU_out), 7);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        checkOutput("no_bubble_out_valid", int'(out_valid), 1);
        checkOutput("no_bubble_ALU_out", int'(ALU_out), 'h30);
        @(posedge clk);
        #1;

        // Reset during the 4th multiply cycle aborts the operation
        applyStimulus(MUL, 8'd7, 8'd9, 8'd63, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_ALU_out", int'(ALU_out), 0);
        checkOutput("abort_carry", int'(carry), 0);
        checkOutput("abort_ovf", int'(ovf), 0);
        checkOutput("abort_zero", int'(zero), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        waitValid("post_abort_add", 1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
